// File: rtl/spi_request_arbiter_pkg.sv
// Shared types and defaults for the SPI request arbiter.
// Holds the FSM state encoding, default parameter values and the length-check helper.
// No logic of its own; imported by the arbiter top and its round-robin picker.
package spi_request_arbiter_pkg;

    localparam int DEF_N_AGENTS    = 4;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_CNT_W       = 6;
    localparam int DEF_ACK_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COMPLETE  = 3'd4
    } state_e;

    // A transfer that moves no bits, or more bits than one word holds, is rejected
    // without ever touching the SPI interface.
    function automatic logic len_invalid(input int total_bits, input int max_bits);
        return (total_bits == 0) || (total_bits > max_bits);
    endfunction

endpackage

// File: rtl/spi_request_arbiter_rr.sv
// Round-robin picker: first requester at or after the rotating pointer wins.
// Winner is combinational from req/ptr; pointer moves to winner+1 on the edge advance is high.
// No backpressure: advance is only honoured when a valid winner exists.
module spi_request_arbiter_rr
    import spi_request_arbiter_pkg::*;
#(
    parameter int N_AGENTS = DEF_N_AGENTS,
    localparam int PTR_W   = $clog2(N_AGENTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_AGENTS-1:0] req_i,
    input  logic                advance_i,
    output logic [N_AGENTS-1:0] winner_o,
    output logic [PTR_W-1:0]    winner_idx_o,
    output logic                valid_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] cand;

    // Scan agents starting at the pointer and wrapping; the first hit wins.
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        valid_o      = 1'b0;
        cand         = '0;
        for (int off = 0; off < N_AGENTS; off++) begin
            cand = PTR_W'((int'(ptr_q) + off) % N_AGENTS);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                winner_o[cand] = 1'b1;
                winner_idx_o  = cand;
            end
        end
        ptr_d = (winner_idx_o == PTR_W'(N_AGENTS - 1)) ? '0 : winner_idx_o + 1'b1;
    end

    // Pointer register: the agent after the last winner becomes highest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance_i && valid_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_request_arbiter.sv
// Multiplexes N agents onto one SPI interface, one latched transaction at a time.
// Latency: grant -> spi_request_action 1 cycle; spi_busy fall -> agent_done 1 cycle.
// Backpressure: no grant while spi_busy is high in IDLE; requests wait until the owner completes.
module spi_request_arbiter
    import spi_request_arbiter_pkg::*;
#(
    parameter int N_AGENTS    = DEF_N_AGENTS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_AGENTS-1:0]        agent_req,
    input  logic [N_AGENTS*DATA_W-1:0] agent_data_out,
    input  logic [N_AGENTS*CNT_W-1:0]  agent_read_bits,
    input  logic [N_AGENTS*CNT_W-1:0]  agent_write_bits,
    output logic [N_AGENTS-1:0]        agent_grant,
    output logic [N_AGENTS-1:0]        agent_done,
    output logic                       agent_err,
    output logic [DATA_W-1:0]          agent_data_in,
    output logic [DATA_W-1:0]          spi_data_out,
    output logic [CNT_W-1:0]           spi_read_bits,
    output logic [CNT_W-1:0]           spi_write_bits,
    output logic                       spi_request_action,
    input  logic                       spi_busy,
    input  logic [DATA_W-1:0]          spi_data_in
);

    localparam int PTR_W     = $clog2(N_AGENTS);
    localparam int ACK_CNT_W = $clog2(ACK_TIMEOUT + 1);

    state_e                state_q, state_d;
    logic [N_AGENTS-1:0]   grant_q, grant_d;
    logic [N_AGENTS-1:0]   done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     data_in_q, data_in_d;
    logic [DATA_W-1:0]     spi_data_q, spi_data_d;
    logic [CNT_W-1:0]      spi_rb_q, spi_rb_d;
    logic [CNT_W-1:0]      spi_wb_q, spi_wb_d;
    logic                  req_act_q, req_act_d;
    logic [ACK_CNT_W-1:0]  ack_cnt_q, ack_cnt_d;

    logic [N_AGENTS-1:0]   arb_winner;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic                  arb_advance;

    logic [DATA_W-1:0]     sel_data;
    logic [CNT_W-1:0]      sel_rb;
    logic [CNT_W-1:0]      sel_wb;
    logic [CNT_W:0]        len_sum;
    logic                  len_bad;

    spi_request_arbiter_rr #(
        .N_AGENTS (N_AGENTS)
    ) u_rr (
        .clk          (clk),
        .reset        (reset),
        .req_i        (agent_req),
        .advance_i    (arb_advance),
        .winner_o     (arb_winner),
        .winner_idx_o (arb_idx),
        .valid_o      (arb_vld)
    );

    // Pick the candidate agent's command fields out of the flat input buses.
    always_comb begin
        sel_data = '0;
        sel_rb   = '0;
        sel_wb   = '0;
        for (int i = 0; i < N_AGENTS; i++) begin
            if (arb_idx == PTR_W'(i)) begin
                sel_data = agent_data_out[i*DATA_W +: DATA_W];
                sel_rb   = agent_read_bits[i*CNT_W +: CNT_W];
                sel_wb   = agent_write_bits[i*CNT_W +: CNT_W];
            end
        end
    end

    // One extra bit so two maximal lengths cannot wrap into a legal-looking total.
    assign len_sum = {1'b0, sel_rb} + {1'b0, sel_wb};
    assign len_bad = len_invalid(int'(len_sum), DATA_W);

    // Next-state and output logic for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        err_d       = 1'b0;
        data_in_d   = data_in_q;
        spi_data_d  = spi_data_q;
        spi_rb_d    = spi_rb_q;
        spi_wb_d    = spi_wb_q;
        req_act_d   = 1'b0;
        ack_cnt_d   = ack_cnt_q;
        arb_advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_vld && !spi_busy) begin
                    arb_advance = 1'b1;
                    grant_d     = arb_winner;
                    spi_data_d  = sel_data;
                    spi_rb_d    = sel_rb;
                    spi_wb_d    = sel_wb;
                    if (len_bad) begin
                        done_d  = arb_winner;
                        err_d   = 1'b1;
                        state_d = ST_COMPLETE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                // Registered pulse: visible during the first WAIT_ACK cycle.
                req_act_d = 1'b1;
                ack_cnt_d = '0;
                state_d   = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (spi_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    state_d = ST_COMPLETE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!spi_busy) begin
                    done_d    = grant_q;
                    data_in_d = spi_data_in;
                    state_d   = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, suppressing any pending done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            data_in_q  <= '0;
            spi_data_q <= '0;
            spi_rb_q   <= '0;
            spi_wb_q   <= '0;
            req_act_q  <= 1'b0;
            ack_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            err_q      <= err_d;
            data_in_q  <= data_in_d;
            spi_data_q <= spi_data_d;
            spi_rb_q   <= spi_rb_d;
            spi_wb_q   <= spi_wb_d;
            req_act_q  <= req_act_d;
            ack_cnt_q  <= ack_cnt_d;
        end
    end

    assign agent_grant        = grant_q;
    assign agent_done         = done_q;
    assign agent_err          = err_q;
    assign agent_data_in      = data_in_q;
    assign spi_data_out       = spi_data_q;
    assign spi_read_bits      = spi_rb_q;
    assign spi_write_bits     = spi_wb_q;
    assign spi_request_action = req_act_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
module tb_spi_request_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int CW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [N-1:0]    agent_req;
    logic [N*DW-1:0] agent_data_out;
    logic [N*CW-1:0] agent_read_bits;
    logic [N*CW-1:0] agent_write_bits;
    logic [N-1:0]    agent_grant;
    logic [N-1:0]    agent_done;
    logic            agent_err;
    logic [DW-1:0]   agent_data_in;
    logic [DW-1:0]   spi_data_out;
    logic [CW-1:0]   spi_read_bits;
    logic [CW-1:0]   spi_write_bits;
    logic            spi_request_action;
    logic            spi_busy;
    logic [DW-1:0]   spi_data_in;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    logic model_en   = 1'b1;
    int   busy_len   = 4;
    int   busy_left  = 0;

    int checks   = 0;
    int failures = 0;

    assign spi_busy = model_busy | force_busy;

    spi_request_arbiter #(
        .N_AGENTS(N), .DATA_W(DW), .CNT_W(CW), .ACK_TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .agent_req(agent_req), .agent_data_out(agent_data_out),
        .agent_read_bits(agent_read_bits), .agent_write_bits(agent_write_bits),
        .agent_grant(agent_grant), .agent_done(agent_done), .agent_err(agent_err),
        .agent_data_in(agent_data_in), .spi_data_out(spi_data_out),
        .spi_read_bits(spi_read_bits), .spi_write_bits(spi_write_bits),
        .spi_request_action(spi_request_action), .spi_busy(spi_busy),
        .spi_data_in(spi_data_in)
    );

    // SPI interface stand-in: busy rises after the start pulse, stays up busy_len cycles.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            model_busy = 1'b0;
            busy_left  = 0;
        end else if (model_busy) begin
            if (busy_left <= 1) model_busy = 1'b0;
            else busy_left--;
        end else if (spi_request_action && model_en) begin
            model_busy = 1'b1;
            busy_left  = busy_len;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_agent(input int a, input logic [31:0] d, input logic [5:0] rb, input logic [5:0] wb);
        agent_data_out[a*DW +: DW]   = d;
        agent_read_bits[a*CW +: CW]  = rb;
        agent_write_bits[a*CW +: CW] = wb;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; agent_req = '0; agent_data_out = '0;
        agent_read_bits = '0; agent_write_bits = '0; spi_data_in = '0;
        repeat (3) tick();
        checks++; if (agent_grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", agent_grant); end
        checks++; if (agent_done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", agent_done); end
        checks++; if (agent_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", agent_err); end
        checks++; if (agent_data_in !== 32'h0) begin failures++; $display("FAIL reset_data_in got=%h exp=0", agent_data_in); end
        checks++; if (spi_data_out !== 32'h0) begin failures++; $display("FAIL reset_spi_data got=%h exp=0", spi_data_out); end
        checks++; if ({spi_read_bits, spi_write_bits} !== 12'h0) begin failures++; $display("FAIL reset_spi_len got=%h/%h exp=0/0", spi_read_bits, spi_write_bits); end
        checks++; if (spi_request_action !== 1'b0) begin failures++; $display("FAIL reset_req_action got=%b exp=0", spi_request_action); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        int g_t = -1, r_t = -1, f_t = -1, d_t = -1, r_cnt = 0;
        logic prev_busy = 1'b0;
        logic [3:0] gv = '0, dv = '0;
        logic e = 1'bx;
        logic [31:0] sdo = '0, di = '0;
        set_agent(1, 32'h0F30_0001, 6'd0, 6'h20);
        spi_data_in = 32'hCAFE_0001; busy_len = 4; model_en = 1'b1;
        agent_req[1] = 1'b1;
        for (int t = 1; t <= 60 && d_t < 0; t++) begin
            tick();
            if (g_t < 0 && agent_grant != 0) begin g_t = t; gv = agent_grant; end
            if (spi_request_action) begin r_cnt++; if (r_t < 0) begin r_t = t; sdo = spi_data_out; end end
            if (prev_busy && !spi_busy && f_t < 0) f_t = t;
            prev_busy = spi_busy;
            if (agent_done != 0) begin d_t = t; dv = agent_done; e = agent_err; di = agent_data_in; agent_req[1] = 1'b0; end
        end
        checks++; if (gv !== 4'b0010) begin failures++; $display("FAIL single_grant got=%b exp=0010", gv); end
        checks++; if (r_t - g_t !== 1) begin failures++; $display("FAIL single_grant_to_req got=%0d exp=1", r_t - g_t); end
        checks++; if (r_cnt !== 1) begin failures++; $display("FAIL single_req_pulses got=%0d exp=1", r_cnt); end
        checks++; if (sdo !== 32'h0F30_0001) begin failures++; $display("FAIL single_spi_data got=%h exp=0f300001", sdo); end
        checks++; if (d_t - f_t !== 1) begin failures++; $display("FAIL single_busy_to_done got=%0d exp=1", d_t - f_t); end
        checks++; if (dv !== 4'b0010) begin failures++; $display("FAIL single_done got=%b exp=0010", dv); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", e); end
        checks++; if (di !== 32'hCAFE_0001) begin failures++; $display("FAIL single_data_in got=%h exp=cafe0001", di); end
        tick();
        checks++; if ({agent_grant, agent_done} !== 8'h0) begin failures++; $display("FAIL single_after got=%b/%b exp=0000/0000", agent_grant, agent_done); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp, dv;
        pulse_reset();
        for (int a = 0; a < N; a++) set_agent(a, 32'h100 + a, 6'd0, 6'd8);
        busy_len = 2; model_en = 1'b1;
        agent_req = 4'hF;
        for (int turn = 0; turn < 5; turn++) begin
            exp = 4'(1 << (turn % 4));
            dv = '0;
            for (int t = 0; t < 40 && dv == 0; t++) begin
                tick();
                dv = agent_done;
            end
            if (turn == 4) agent_req = '0;
            checks++; if (dv !== exp) begin failures++; $display("FAIL rr_order turn=%0d got=%b exp=%b", turn, dv, exp); end
            tick();
            checks++; if (agent_done !== 4'b0) begin failures++; $display("FAIL rr_pulse turn=%0d got=%b exp=0000", turn, agent_done); end
        end
        tick();
    endtask

    task automatic test_readback();
        logic [3:0] dv = '0;
        logic e = 1'bx;
        logic [5:0] rb = '0, wb = '0;
        logic [31:0] di = '0;
        set_agent(2, 32'h0000_1234, 6'd8, 6'd16);
        spi_data_in = 32'h0000_00A5; busy_len = 3;
        agent_req[2] = 1'b1;
        for (int t = 0; t < 40 && dv == 0; t++) begin
            tick();
            if (agent_grant == 4'b0100) begin rb = spi_read_bits; wb = spi_write_bits; end
            if (agent_done != 0) begin dv = agent_done; e = agent_err; di = agent_data_in; agent_req[2] = 1'b0; end
        end
        checks++; if (rb !== 6'd8 || wb !== 6'd16) begin failures++; $display("FAIL rb_lengths got=%0d/%0d exp=8/16", rb, wb); end
        checks++; if (dv !== 4'b0100) begin failures++; $display("FAIL rb_done got=%b exp=0100", dv); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rb_err got=%b exp=0", e); end
        checks++; if (di !== 32'h0000_00A5) begin failures++; $display("FAIL rb_data got=%h exp=000000a5", di); end
        spi_data_in = 32'hFFFF_0000;
        tick();
        checks++; if (agent_data_in !== 32'h0000_00A5) begin failures++; $display("FAIL rb_hold got=%h exp=000000a5", agent_data_in); end
    endtask

    task automatic test_bad_length();
        logic [3:0] dv;
        logic e;
        int ra;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_agent(3, 32'h0000_3333, 6'd0, 6'd0);
            else set_agent(3, 32'h0000_3334, 6'd20, 6'd20);
            ra = 0; dv = '0; e = 1'bx;
            agent_req[3] = 1'b1;
            for (int t = 0; t < 2 && dv == 0; t++) begin
                tick();
                if (spi_request_action) ra++;
                dv = agent_done; e = agent_err;
            end
            agent_req[3] = 1'b0;
            repeat (3) begin tick(); if (spi_request_action) ra++; end
            checks++; if (dv !== 4'b1000) begin failures++; $display("FAIL badlen_done case=%0d got=%b exp=1000", k, dv); end
            checks++; if (e !== 1'b1) begin failures++; $display("FAIL badlen_err case=%0d got=%b exp=1", k, e); end
            checks++; if (ra !== 0) begin failures++; $display("FAIL badlen_no_req case=%0d got=%0d exp=0", k, ra); end
        end
        checks++; if (agent_data_in !== 32'h0000_00A5) begin failures++; $display("FAIL badlen_data_kept got=%h exp=000000a5", agent_data_in); end
    endtask

    task automatic test_ack_timeout();
        int r_t = -1, d_t = -1;
        logic [3:0] dv = '0;
        logic e = 1'bx;
        logic [31:0] di = '0;
        model_en = 1'b0;
        spi_data_in = 32'h1234_5678;
        set_agent(0, 32'h0000_0A0A, 6'd0, 6'd8);
        agent_req[0] = 1'b1;
        for (int t = 1; t <= 60 && d_t < 0; t++) begin
            tick();
            if (spi_request_action && r_t < 0) r_t = t;
            if (agent_done != 0) begin d_t = t; dv = agent_done; e = agent_err; di = agent_data_in; agent_req[0] = 1'b0; end
        end
        model_en = 1'b1;
        tick();
        checks++; if (d_t - r_t !== 15) begin failures++; $display("FAIL timeout_cycles got=%0d exp=15", d_t - r_t); end
        checks++; if (dv !== 4'b0001) begin failures++; $display("FAIL timeout_done got=%b exp=0001", dv); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", e); end
        checks++; if (di !== 32'h0000_00A5) begin failures++; $display("FAIL timeout_data_kept got=%h exp=000000a5", di); end
    endtask

    task automatic test_busy_block();
        logic seen = 1'b0;
        logic [3:0] gv = '0, dv = '0;
        logic e = 1'bx;
        set_agent(1, 32'h0000_BB01, 6'd4, 6'd4);
        busy_len = 2; force_busy = 1'b1;
        agent_req[1] = 1'b1;
        repeat (6) begin tick(); if (agent_grant != 0) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL busy_block_grant got=%b exp=0", seen); end
        force_busy = 1'b0;
        for (int t = 0; t < 3 && gv == 0; t++) begin tick(); gv = agent_grant; end
        checks++; if (gv !== 4'b0010) begin failures++; $display("FAIL busy_release_grant got=%b exp=0010", gv); end
        for (int t = 0; t < 30 && dv == 0; t++) begin tick(); dv = agent_done; e = agent_err; end
        agent_req[1] = 1'b0;
        tick();
        checks++; if (dv !== 4'b0010 || e !== 1'b0) begin failures++; $display("FAIL busy_done got=%b err=%b exp=0010 err=0", dv, e); end
    endtask

    task automatic test_reset_mid();
        logic seen_busy = 1'b0;
        logic [3:0] gv = '0, dv = '0;
        set_agent(2, 32'h0000_2222, 6'd0, 6'd16);
        set_agent(3, 32'h0000_3335, 6'd0, 6'd8);
        busy_len = 10;
        agent_req = 4'b0100;
        for (int t = 0; t < 20 && !seen_busy; t++) begin tick(); seen_busy = spi_busy; end
        checks++; if (seen_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_seen got=%b exp=1", seen_busy); end
        agent_req = 4'b1110;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (agent_grant !== 4'b0) begin failures++; $display("FAIL rstmid_grant got=%b exp=0000", agent_grant); end
        checks++; if (agent_done !== 4'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0000", agent_done); end
        checks++; if (spi_request_action !== 1'b0) begin failures++; $display("FAIL rstmid_req_action got=%b exp=0", spi_request_action); end
        checks++; if (spi_data_out !== 32'h0 || agent_data_in !== 32'h0) begin failures++; $display("FAIL rstmid_data got=%h/%h exp=0/0", spi_data_out, agent_data_in); end
        reset = 1'b0;
        for (int t = 0; t < 5 && gv == 0; t++) begin tick(); gv = agent_grant; end
        checks++; if (gv !== 4'b0010) begin failures++; $display("FAIL rstmid_regrant got=%b exp=0010", gv); end
        for (int t = 0; t < 40 && dv == 0; t++) begin tick(); dv = agent_done; end
        agent_req = '0;
        checks++; if (dv !== 4'b0010) begin failures++; $display("FAIL rstmid_done_after got=%b exp=0010", dv); end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_readback();
        test_bad_length();
        test_ack_timeout();
        test_busy_block();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
